// File: rtl/wrapping_read_controller_pkg.sv
// Shared sizing helpers and types for the wrapping read/write pointer controllers.
package wrapping_read_controller_pkg;

  typedef enum logic [1:0] {
    LVL_HOLD,
    LVL_INC,
    LVL_DEC
  } level_op_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic int unsigned level_width(input int unsigned depth);
    return clog2(depth + 1);
  endfunction

  function automatic int unsigned index_max(input int unsigned depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/wrapping_read_controller_lap.sv
// Wrapping index 0..DEPTH-1 with a lap bit that toggles on every wrap; shared by read and write sides.
module wrapping_lap_index
  import wrapping_read_controller_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  output logic [WIDTH-1:0] index,
  output logic             lap
);

  logic [WIDTH-1:0] index_next;
  logic             lap_next;

  generate
    if (is_pow2(DEPTH)) begin : g_pow2
      // Carry out of the index lands in the lap bit.
      always_comb {lap_next, index_next} = {lap, index} + (WIDTH + 1)'(1);
    end else begin : g_wrap
      localparam logic [WIDTH-1:0] LAST = WIDTH'(index_max(DEPTH));
      always_comb begin
        index_next = index + WIDTH'(1);
        lap_next   = lap;
        if (index == LAST) begin
          index_next = '0;
          lap_next   = ~lap;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      index <= '0;
      lap   <= 1'b0;
    end else if (advance) begin
      index <= index_next;
      lap   <= lap_next;
    end
  end

endmodule

// File: rtl/wrapping_read_controller.sv
// Consumer-side read pointer / occupancy controller for a circular buffer of any depth >= 2.
// Define WRAPPING_READ_CONTROLLER_OVERFLOW_EN to add the sticky overflow flag and its clear.
module wrapping_read_controller
  import wrapping_read_controller_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WIDTH       = clog2(DEPTH),
  parameter int unsigned LEVEL_WIDTH = level_width(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   write_push,
  output logic                   read_valid,
  input  logic                   read_ready,
  output logic [WIDTH-1:0]       read_index,
  output logic                   read_lap,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   empty,
  output logic                   full
`ifdef WRAPPING_READ_CONTROLLER_OVERFLOW_EN
  ,
  output logic                   overflow,
  input  logic                   overflow_clear
`endif
);

  localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(DEPTH);

  logic                   pop;
  logic                   push;
  level_op_e              op;
  logic [LEVEL_WIDTH-1:0] level_next;

  assign read_valid = ~empty;
  assign pop        = ~empty & read_ready;
  // A pop in the same cycle frees the slot a full-buffer push needs.
  assign push       = write_push & (~full | pop);

  always_comb begin
    op = LVL_HOLD;
    if (push && !pop)      op = LVL_INC;
    else if (pop && !push) op = LVL_DEC;
  end

  always_comb begin
    level_next = level;
    case (op)
      LVL_INC: level_next = level + LEVEL_WIDTH'(1);
      LVL_DEC: level_next = level - LEVEL_WIDTH'(1);
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      level <= level_next;
      empty <= (level_next == '0);
      full  <= (level_next == FULL_LEVEL);
    end
  end

  wrapping_lap_index #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_read_ptr (
    .clock   (clock),
    .reset   (reset),
    .advance (pop),
    .index   (read_index),
    .lap     (read_lap)
  );

`ifdef WRAPPING_READ_CONTROLLER_OVERFLOW_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          overflow <= 1'b0;
    else if (write_push && full && !pop) overflow <= 1'b1;
    else if (overflow_clear)            overflow <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_wrapping_read_controller.sv
// Directed and model-checked bench for wrapping_read_controller at DEPTH 3, 4 and 5.
module tb_wrapping_read_controller;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic       p3 = 1'b0, r3 = 1'b0, v3, lap3, e3, f3;
  logic [1:0] idx3, lvl3;
  logic       p4 = 1'b0, r4 = 1'b0, v4, lap4, e4, f4;
  logic [1:0] idx4;
  logic [2:0] lvl4;
  logic       p5 = 1'b0, r5 = 1'b0, v5, lap5, e5, f5;
  logic [2:0] idx5, lvl5;
`ifdef WRAPPING_READ_CONTROLLER_OVERFLOW_EN
  logic ovc3 = 1'b0, ovc4 = 1'b0, ovc5 = 1'b0;
  logic ov3, ov4, ov5;
`endif

  // {read_index, read_lap, level, empty, full, read_valid}
  logic [8:0]  s3;
  logic [10:0] s5;
  assign s3 = {idx3, lap3, lvl3, e3, f3, v3};
  assign s5 = {idx5, lap5, lvl5, e5, f5, v5};

  wrapping_read_controller #(.DEPTH(3)) u3 (
    .clock(clock), .reset(reset), .write_push(p3), .read_valid(v3), .read_ready(r3),
    .read_index(idx3), .read_lap(lap3), .level(lvl3), .empty(e3), .full(f3)
`ifdef WRAPPING_READ_CONTROLLER_OVERFLOW_EN
    , .overflow(ov3), .overflow_clear(ovc3)
`endif
  );

  wrapping_read_controller #(.DEPTH(4)) u4 (
    .clock(clock), .reset(reset), .write_push(p4), .read_valid(v4), .read_ready(r4),
    .read_index(idx4), .read_lap(lap4), .level(lvl4), .empty(e4), .full(f4)
`ifdef WRAPPING_READ_CONTROLLER_OVERFLOW_EN
    , .overflow(ov4), .overflow_clear(ovc4)
`endif
  );

  wrapping_read_controller #(.DEPTH(5)) u5 (
    .clock(clock), .reset(reset), .write_push(p5), .read_valid(v5), .read_ready(r5),
    .read_index(idx5), .read_lap(lap5), .level(lvl5), .empty(e5), .full(f5)
`ifdef WRAPPING_READ_CONTROLLER_OVERFLOW_EN
    , .overflow(ov5), .overflow_clear(ovc5)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    p3 = 1'b0; r3 = 1'b0; p4 = 1'b0; r4 = 1'b0; p5 = 1'b0; r5 = 1'b0;
`ifdef WRAPPING_READ_CONTROLLER_OVERFLOW_EN
    ovc3 = 1'b0; ovc4 = 1'b0; ovc5 = 1'b0;
`endif
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] rst_exp;
    rst_exp = {2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
    #1 reset = 1'b1;
    #1;
    total++;
    if (s3 !== rst_exp) begin
      bad++; $display("FAIL reset_state: got %b want %b", s3, rst_exp);
    end
    step();
    reset = 1'b0;
    p3 = 1'b1;
    step(); step();
    p3 = 1'b0;
    total++;
    if (s3 !== {2'd0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL pre_reset_level2: got %b want %b", s3, {2'd0, 1'b0, 2'd2, 3'b001});
    end
    reset = 1'b1;
    #1;
    total++;
    if (s3 !== rst_exp) begin
      bad++; $display("FAIL async_reset: got %b want %b", s3, rst_exp);
    end
    #1 reset = 1'b0;
    step();
    total++;
    if (s3 !== rst_exp) begin
      bad++; $display("FAIL idle_after_reset: got %b want %b", s3, rst_exp);
    end
  endtask

  task automatic test_fill_drain();
    logic [8:0] exp;
    do_reset();
    p3 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      exp = {2'd0, 1'b0, 2'(k), 1'b0, 1'(k == 3), 1'b1};
      total++;
      if (s3 !== exp) begin
        bad++; $display("FAIL fill_%0d: got %b want %b", k, s3, exp);
      end
    end
    p3 = 1'b0;
    r3 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp = {2'((k >= 3) ? 0 : k), 1'(k >= 3), 2'((k < 3) ? 3 - k : 0), 1'(k >= 3), 1'b0, 1'(k < 3)};
      total++;
      if (s3 !== exp) begin
        bad++; $display("FAIL drain_%0d: got %b want %b", k, s3, exp);
      end
    end
    r3 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp;
    do_reset();
    p5 = 1'b1;
    step(); step();
    r5 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp = {3'(k % 5), 1'((k / 5) % 2 == 1), 3'd2, 1'b0, 1'b0, 1'b1};
      total++;
      if (s5 !== exp) begin
        bad++; $display("FAIL b2b_%0d: got %b want %b", k, s5, exp);
      end
    end
    p5 = 1'b0;
    r5 = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    p3 = 1'b1;
    step(); step(); step();
    step();
    total++;
    if (s3 !== {2'd0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL full_push_alone: got %b want %b", s3, {2'd0, 1'b0, 2'd3, 3'b011});
    end
`ifdef WRAPPING_READ_CONTROLLER_OVERFLOW_EN
    total++;
    if (ov3 !== 1'b1) begin
      bad++; $display("FAIL overflow_set: got %b want 1", ov3);
    end
    ovc3 = 1'b1;
    step();
    total++;
    if (ov3 !== 1'b1) begin
      bad++; $display("FAIL overflow_set_wins: got %b want 1", ov3);
    end
    p3 = 1'b0;
    step();
    ovc3 = 1'b0;
    total++;
    if (ov3 !== 1'b0) begin
      bad++; $display("FAIL overflow_clear: got %b want 0", ov3);
    end
`else
    p3 = 1'b0;
    step();
`endif
    p3 = 1'b1;
    r3 = 1'b1;
    step();
    p3 = 1'b0;
    r3 = 1'b0;
    total++;
    if (s3 !== {2'd1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL full_push_pop: got %b want %b", s3, {2'd1, 1'b0, 2'd3, 3'b011});
    end
`ifdef WRAPPING_READ_CONTROLLER_OVERFLOW_EN
    total++;
    if (ov3 !== 1'b0) begin
      bad++; $display("FAIL overflow_on_push_pop: got %b want 0", ov3);
    end
`endif
  endtask

  task automatic test_empty();
    do_reset();
    p3 = 1'b1;
    r3 = 1'b1;
    step();
    p3 = 1'b0;
    total++;
    if (s3 !== {2'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL empty_push_ready: got %b want %b", s3, {2'd0, 1'b0, 2'd1, 3'b001});
    end
    step();
    r3 = 1'b0;
    total++;
    if (s3 !== {2'd1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL empty_then_pop: got %b want %b", s3, {2'd1, 1'b0, 2'd0, 3'b100});
    end
  endtask

  task automatic test_random();
    int dep[2];
    int m_idx[2], m_lap[2], m_lvl[2], m_w[2];
    int g_idx, g_lap, g_lvl, g_e, g_f;
    bit wp[2], rd[2], pop[2], push[2];
    int phase;
    dep = '{4, 5};
    m_idx = '{0, 0}; m_lap = '{0, 0}; m_lvl = '{0, 0}; m_w = '{0, 0};
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      phase = (c / 200) % 2;
      for (int j = 0; j < 2; j++) begin
        wp[j]   = $urandom_range(0, 9) < ((phase == 1) ? 7 : 3);
        rd[j]   = $urandom_range(0, 9) < ((phase == 1) ? 3 : 7);
        pop[j]  = (m_lvl[j] > 0) && rd[j];
        push[j] = wp[j] && ((m_lvl[j] < dep[j]) || pop[j]);
      end
      p4 = wp[0]; r4 = rd[0];
      p5 = wp[1]; r5 = rd[1];
      step();
      for (int j = 0; j < 2; j++) begin
        if (pop[j]) begin
          m_idx[j] = (m_idx[j] + 1) % dep[j];
          if (m_idx[j] == 0) m_lap[j] = 1 - m_lap[j];
        end
        if (push[j]) m_w[j] = (m_w[j] + 1) % dep[j];
        m_lvl[j] = m_lvl[j] + int'(push[j]) - int'(pop[j]);
        g_idx = (j == 0) ? int'(idx4) : int'(idx5);
        g_lap = (j == 0) ? int'(lap4) : int'(lap5);
        g_lvl = (j == 0) ? int'(lvl4) : int'(lvl5);
        g_e   = (j == 0) ? int'(e4) : int'(e5);
        g_f   = (j == 0) ? int'(f4) : int'(f5);
        total++;
        if (g_idx != m_idx[j] || g_lap != m_lap[j] || g_lvl != m_lvl[j] ||
            g_e != int'(m_lvl[j] == 0) || g_f != int'(m_lvl[j] == dep[j])) begin
          bad++;
          $display("FAIL rand_d%0d cyc %0d: got idx=%0d lap=%0d lvl=%0d e=%0d f=%0d want idx=%0d lap=%0d lvl=%0d",
                   dep[j], c, g_idx, g_lap, g_lvl, g_e, g_f, m_idx[j], m_lap[j], m_lvl[j]);
        end
        total++;
        if ((g_idx + g_lvl) % dep[j] != m_w[j]) begin
          bad++;
          $display("FAIL write_index_d%0d cyc %0d: got %0d want %0d",
                   dep[j], c, (g_idx + g_lvl) % dep[j], m_w[j]);
        end
      end
    end
    p4 = 1'b0; r4 = 1'b0; p5 = 1'b0; r5 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full();
    test_empty();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
